kws_frame_sequencer: RTL

Controller for the audio front-end framing buffer of the keyword-spotting pipeline. Sits between the serializer/pre-emphasis stage, which writes one sample per `sample_valid`, and the Hanning window stage, which reads frames. Owns write and read addressing of an external circular sample RAM and schedules overlapping frames of FRAME_LEN samples at a hop of HOP. Flags overrun when the writer would overwrite unread frame data.

---
 rtl/kws_frame_pkg.sv | 21 ++
 rtl/kws_ring_ptr.sv | 40 ++++
 rtl/kws_frame_sequencer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/kws_frame_pkg.sv
// Shared types, default geometry and configuration checks for the
// keyword-spotting framing sequencer.
package kws_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam int DEF_DEPTH     = 64;
  localparam int DEF_FRAME_LEN = 32;
  localparam int DEF_HOP       = 16;

  // Legal geometry: power-of-two RAM and HOP <= FRAME_LEN <= DEPTH.
  function automatic bit cfg_ok(input int depth, input int frame_len, input int hop);
    return (depth >= 2) && ((depth & (depth - 1)) == 0) &&
           (hop >= 1) && (hop <= frame_len) && (frame_len <= depth);
  endfunction

endpackage

// File: rtl/kws_ring_ptr.sv
// Circular-buffer pointer with a wrap bit above the RAM address bits;
// steps by one sample or by one frame hop.
module kws_ring_ptr #(
  parameter int AW  = 6,
  parameter int HOP = 16
) (
  input  logic        Clk,
  input  logic        reset_n,
  input  logic        i_inc,
  input  logic        i_add_hop,
  output logic [AW:0] o_ptr
);

  localparam logic [AW:0] ONE_W = (AW + 1)'(1);
  localparam logic [AW:0] HOP_W = (AW + 1)'(HOP);

  logic [AW:0] r_ptr;
  logic [AW:0] w_ptr_next;

  always_comb begin
    w_ptr_next = r_ptr;
    if (i_inc) begin
      w_ptr_next = w_ptr_next + ONE_W;
    end
    if (i_add_hop) begin
      w_ptr_next = w_ptr_next + HOP_W;
    end
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= w_ptr_next;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/kws_frame_sequencer.sv
// Framing-buffer controller: owns write/read addressing of the circular
// sample RAM and schedules overlapping frames for the window stage.
module kws_frame_sequencer
  import kws_frame_pkg::*;
#(
  parameter int  DEPTH     = DEF_DEPTH,
  parameter int  FRAME_LEN = DEF_FRAME_LEN,
  parameter int  HOP       = DEF_HOP,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic          Clk,
  input  logic          reset_n,
  input  logic          enable,
  input  logic          sample_valid,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [AW-1:0] rd_addr,
  output logic          rd_first,
  output logic          rd_last,
  output logic          frame_done,
  output logic          busy,
  output logic [AW:0]   occupancy,
  output logic          overrun,
  input  logic          clr_overrun,
  output logic [15:0]   frame_cnt
);

  if (!cfg_ok(DEPTH, FRAME_LEN, HOP)) begin : g_cfg_err
    $error("kws_frame_sequencer: illegal DEPTH/FRAME_LEN/HOP combination");
  end

  localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   FLEN_W   = (AW + 1)'(FRAME_LEN);
  localparam logic [AW-1:0] LAST_IDX = AW'(FRAME_LEN - 1);

  logic [AW:0]   w_wr_ptr;
  logic [AW:0]   w_frame_base;
  logic [AW:0]   w_occ;
  logic          w_full;
  logic          w_accept;
  logic          w_drop;
  logic          w_hs;
  logic          w_done;

  state_e        r_state;
  state_e        w_state_next;
  logic [AW-1:0] r_rd_idx;
  logic [AW-1:0] w_rd_idx_next;

  logic          r_rd_valid, w_rd_valid_next;
  logic          r_rd_first, w_rd_first_next;
  logic          r_rd_last,  w_rd_last_next;
  logic [AW-1:0] r_rd_addr,  w_rd_addr_next;
  logic          r_frame_done, w_frame_done_next;
  logic          r_busy,     w_busy_next;
  logic          r_overrun;
  logic [15:0]   r_frame_cnt;

  // Accept check always uses the pre-update occupancy, even in DONE.
  assign w_occ    = w_wr_ptr - w_frame_base;
  assign w_full   = !(w_occ < DEPTH_W);
  assign w_accept = reset_n && sample_valid && !w_full;
  assign w_drop   = sample_valid && w_full;
  assign w_hs     = r_rd_valid && rd_ready;
  assign w_done   = (r_state == ST_DONE);

  kws_ring_ptr #(.AW(AW), .HOP(HOP)) u_wr_ptr (
    .Clk       (Clk),
    .reset_n   (reset_n),
    .i_inc     (w_accept),
    .i_add_hop (1'b0),
    .o_ptr     (w_wr_ptr)
  );

  kws_ring_ptr #(.AW(AW), .HOP(HOP)) u_frame_base (
    .Clk       (Clk),
    .reset_n   (reset_n),
    .i_inc     (1'b0),
    .i_add_hop (w_done),
    .o_ptr     (w_frame_base)
  );

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_rd_idx <= '0;
    end else begin
      r_state  <= w_state_next;
      r_rd_idx <= w_rd_idx_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_rd_idx_next = r_rd_idx;
    case (r_state)
      ST_IDLE: begin
        if (enable && (w_occ >= FLEN_W)) begin
          w_state_next  = ST_STREAM;
          w_rd_idx_next = '0;
        end
      end
      ST_STREAM: begin
        if (w_hs) begin
          if (r_rd_idx == LAST_IDX) begin
            w_state_next = ST_DONE;
          end else begin
            w_rd_idx_next = r_rd_idx + AW'(1);
          end
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Outputs are computed from the next state so that they come straight off flops.
  always_comb begin
    w_rd_valid_next   = (w_state_next == ST_STREAM);
    w_rd_first_next   = 1'b0;
    w_rd_last_next    = 1'b0;
    w_rd_addr_next    = '0;
    if (w_rd_valid_next) begin
      w_rd_first_next = (w_rd_idx_next == '0);
      w_rd_last_next  = (w_rd_idx_next == LAST_IDX);
      w_rd_addr_next  = w_frame_base[AW-1:0] + w_rd_idx_next;
    end
    w_frame_done_next = (w_state_next == ST_DONE);
    w_busy_next       = (w_state_next != ST_IDLE);
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_valid   <= 1'b0;
      r_rd_first   <= 1'b0;
      r_rd_last    <= 1'b0;
      r_rd_addr    <= '0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_rd_valid   <= w_rd_valid_next;
      r_rd_first   <= w_rd_first_next;
      r_rd_last    <= w_rd_last_next;
      r_rd_addr    <= w_rd_addr_next;
      r_frame_done <= w_frame_done_next;
      r_busy       <= w_busy_next;
    end
  end

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overrun   <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (clr_overrun) begin
        r_overrun <= 1'b0;
      end
      if (w_done) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  assign wr_en      = w_accept;
  assign wr_addr    = w_wr_ptr[AW-1:0];
  assign rd_valid   = r_rd_valid;
  assign rd_addr    = r_rd_addr;
  assign rd_first   = r_rd_first;
  assign rd_last    = r_rd_last;
  assign frame_done = r_frame_done;
  assign busy       = r_busy;
  assign occupancy  = w_occ;
  assign overrun    = r_overrun;
  assign frame_cnt  = r_frame_cnt;

endmodule
